// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// No logic lives here. It holds the FSM encoding, the bubble word, the PC step and the word-align helper.
// Backpressure: not applicable.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [63:0] PC_STEP   = 64'd4;

    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_out_buf.sv
// One-entry holding register for the instruction presented to IF/ID.
// Latency: a load appears on the outputs one cycle later. Priority is clear, then load, then consume.
// Backpressure: contents hold while neither consumed nor cleared.
module fetch_out_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        consume,
    input  logic        clear,
    input  logic [63:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        ob_valid,
    output logic [63:0] ob_pc,
    output logic [31:0] ob_instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_valid <= 1'b0;
            ob_pc    <= 64'h0;
            ob_instr <= 32'h0;
        end else if (clear) begin
            ob_valid <= 1'b0;
        end else if (load) begin
            ob_valid <= 1'b1;
            ob_pc    <= load_pc;
            ob_instr <= load_instr;
        end else if (consume) begin
            ob_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Issues word fetches and feeds IF/ID through a one-entry buffer.
// Latency: one cycle from imem_ready to the IF/ID outputs. Zero-wait memory sustains one instruction per cycle.
// Backpressure: stall holds the buffer and blocks new requests. Branches flush and drain any outstanding fetch.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [63:0] PC_addr,
    output logic [31:0] Instruc,
    output logic        IFID_Write,
    output logic        Flush
);

    fetch_state_t state, state_nxt;
    logic [63:0]  pc, pc_nxt;
    logic [63:0]  req_addr, req_addr_nxt;
    logic         req_pend, req_pend_nxt;
    logic         ob_valid;
    logic [63:0]  ob_pc;
    logic [31:0]  ob_instr;
    logic         consume, new_req, ob_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_addr <= 64'h0;
            req_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            req_pend <= req_pend_nxt;
        end
    end

    always_comb begin
        consume      = ob_valid & ~stall & ~branch_taken;
        // A redirect never opens a fresh request; only an already-held one stays on the bus.
        new_req      = (state == S_REQ) & ~req_pend & ~branch_taken & (~ob_valid | consume);
        imem_req     = req_pend | new_req;
        imem_addr    = req_pend ? req_addr : pc;
        ob_load      = (state == S_REQ) & imem_req & imem_ready & ~branch_taken;

        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        req_pend_nxt = req_pend;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                req_pend_nxt = imem_req & ~imem_ready;
                if (imem_req & ~imem_ready & branch_taken)
                    state_nxt = S_DRAIN;
                if (new_req)
                    req_addr_nxt = pc;
                if (ob_load)
                    pc_nxt = imem_addr + PC_STEP;
            end
            S_DRAIN: begin
                if (imem_ready) begin
                    req_pend_nxt = 1'b0;
                    state_nxt    = S_REQ;
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                req_pend_nxt = 1'b0;
            end
        endcase

        if (branch_taken)
            pc_nxt = align_word(branch_target);
    end

    fetch_out_buf u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ob_load),
        .consume    (consume),
        .clear      (branch_taken),
        .load_pc    (imem_addr),
        .load_instr (imem_rdata),
        .ob_valid   (ob_valid),
        .ob_pc      (ob_pc),
        .ob_instr   (ob_instr)
    );

    assign PC_addr    = ob_pc;
    assign Instruc    = ob_valid ? ob_instr : NOP_INSTR;
    assign IFID_Write = (state != S_IDLE) & ~stall;
    assign Flush      = branch_taken | (state == S_IDLE);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 stall  input  1  hazard hold from decode; 1 = IF/ID must not advance.
REQ-005 branch_taken  input  1  one-cycle redirect pulse from EX.
REQ-006 branch_target  input  64  redirect address, valid when branch_taken=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  64  request address, word aligned.
REQ-009 imem_ready  input  1  response strobe; imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 PC_addr  output  64  PC of instruction presented to IF/ID.
REQ-012 Instruc  output  32  instruction presented to IF/ID; 32'h0 = bubble.
REQ-013 IFID_Write  output  1  IF/ID write enable.
REQ-014 Flush  output  1  IF/ID clear.

Function
REQ-015 Registered state SHALL be: pc, req_addr, state (S_IDLE, S_REQ, S_DRAIN), and a one-entry output buffer (ob_valid, ob_pc, ob_instr).
REQ-016 Memory protocol SHALL be: once imem_req=1 it stays 1 with imem_addr stable until the cycle imem_ready=1; imem_ready with imem_req=0 SHALL be ignored.
REQ-017 S_IDLE: imem_req=0, Flush=1, IFID_Write=0; next state S_REQ unconditionally.
REQ-018 consume = ob_valid & ~stall & ~branch_taken; new requests SHALL only start in S_REQ when (~ob_valid | consume).
REQ-019 In S_REQ, imem_addr SHALL equal pc for a new request and req_addr for a held one; req_addr latches the issued address.
REQ-020 On imem_ready in S_REQ without branch_taken: ob_pc<=req address, ob_instr<=imem_rdata, ob_valid<=1, pc<=address+4.
REQ-021 pc+4 SHALL wrap modulo 2^64; no overflow flag.
REQ-022 ob_valid SHALL clear on consume unless refilled the same cycle; zero-wait memory SHALL sustain one instruction per cycle.
REQ-023 Outputs: PC_addr=ob_pc, Instruc = ob_valid ? ob_instr : 32'h0, IFID_Write = ~stall (0 in S_IDLE), Flush = branch_taken | (state==S_IDLE).
REQ-024 branch_taken SHALL win over stall and over imem_ready: pc<=branch_target with bits [1:0] forced to 0, ob_valid<=0, Flush=1 that cycle.
REQ-025 branch_taken while a request is outstanding and imem_ready=0: enter S_DRAIN, hold imem_req/req_addr until imem_ready, discard data, then S_REQ at new pc.
REQ-026 branch_taken in the same cycle as imem_ready: response discarded, state stays S_REQ, next request to target on next cycle.
REQ-027 branch_taken in S_DRAIN: pc updated again; drain continues; only latest target fetched.
REQ-028 stall with ob_valid=1: ob contents held; no new request issued.

Reset
REQ-029 rst_n=0 SHALL immediately force state=S_IDLE, pc=RESET_PC, req_addr=0, ob_valid=0, ob_pc=0, ob_instr=0, imem_req=0, Flush=1, IFID_Write=0.
REQ-030 Reset mid-request SHALL abandon the transaction; imem_ready during reset is ignored.

Structure
REQ-031 Shared package SHALL hold the state enum, NOP_INSTR=32'h0 and PC_STEP=64'd4.
REQ-032 One sub-module fetch_out_buf SHALL implement the one-entry output buffer (load, consume, clear).

Verification
REQ-033 Reset release, RESET_PC=0, imem_ready=1 always, rdata=addr-tagged -> after S_IDLE, PC_addr 0,4,8,... one per cycle, Flush=1 only in S_IDLE cycle.
REQ-034 imem_ready delayed 3 cycles for addr 8 -> imem_addr=8 held stable 3 cycles, Instruc=0 bubble during wait, then PC_addr=8.
REQ-035 stall=1 for 2 cycles with ob_valid -> IFID_Write=0, PC_addr/Instruc unchanged, imem_req=0, resumes in order.
REQ-036 branch_taken, target=64'h1003, while request to 0x10 pending -> Flush=1, S_DRAIN until ready, 0x10 data dropped, next imem_addr=64'h1000.
REQ-037 pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=64'h0.
REQ-038 rst_n low mid-wait -> all outputs at reset values same cycle; fetch restarts at RESET_PC.
